// File: rtl/add_op_fifo_pkg.sv
// rtl/add_op_fifo_pkg.sv - operand-pair types shared by the adder input buffer
package add_pkg;

    localparam int DATA_W = 8;
    localparam int SUM_W  = DATA_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } add_op_t;

    // Reference sum of a stored pair, carry included
    function automatic logic [SUM_W-1:0] op_sum(input add_op_t op);
        return SUM_W'(op.a) + SUM_W'(op.b);
    endfunction

endpackage

// File: rtl/add_op_fifo_if.sv
// rtl/add_op_fifo_if.sv - producer/consumer handshake bundle of the operand buffer
interface add_op_fifo_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = add_pkg::DATA_W
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_ready;
    logic [DATA_W-1:0] ina;
    logic [DATA_W-1:0] inb;
    logic              out_valid;
    logic              out_ready;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, ina, inb, out_valid, level, full, empty
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, ina, inb, out_valid, level, full, empty
    );
endinterface

// File: rtl/add_op_fifo_ram.sv
// rtl/add_op_fifo_ram.sv - DEPTH x add_op_t storage, one write port, async read
module add_op_ram
    import add_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  add_op_t          wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output add_op_t          rdata_o
);

    add_op_t mem_q [DEPTH];

    // Contents are deliberately left unreset; validity is tracked by the level counter
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/add_op_fifo.sv
// rtl/add_op_fifo.sv - operand-pair FIFO feeding the 8-bit adder's ina/inb inputs
module add_op_fifo
    import add_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    add_op_fifo_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic    full_w, empty_w, push_w, pop_w;
    add_op_t wdata_w, rdata_w;

    // Status comes only from the registered level, so no in_valid/out_ready path reaches it
    assign full_w  = (level_q == LVL_W'(DEPTH));
    assign empty_w = (level_q == '0);
    assign push_w  = bus.in_valid  && !full_w;
    assign pop_w   = bus.out_ready && !empty_w;

    assign wdata_w.a = bus.in_a;
    assign wdata_w.b = bus.in_b;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_w) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_w && !pop_w) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_w && !push_w) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    add_op_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (push_w),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata_w),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_w)
    );

    // Stale storage must never leak onto the adder inputs while empty
    assign bus.ina       = empty_w ? '0 : rdata_w.a;
    assign bus.inb       = empty_w ? '0 : rdata_w.b;
    assign bus.out_valid = !empty_w;
    assign bus.in_ready  = !full_w;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.level     = level_q;

endmodule

// File: tb/tb_add_op_fifo.sv
// tb/tb_add_op_fifo.sv - directed bench with queue reference model for add_op_fifo
module tb_add_op_fifo;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    add_op_fifo_if #(.DEPTH(DEPTH)) bus ();

    add_op_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of {a,b} pairs, bounded at DEPTH
    logic [15:0] model_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            automatic bit do_pop  = bus.out_ready && (model_q.size() > 0);
            automatic bit do_push = bus.in_valid  && (model_q.size() < DEPTH);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({bus.in_a, bus.in_b});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            automatic int sz = model_q.size();
            automatic logic [15:0] head = (sz > 0) ? model_q[0] : 16'h0;
            chk("m_level",     32'(bus.level),     32'(sz));
            chk("m_out_valid", 32'(bus.out_valid), 32'(sz > 0));
            chk("m_ina",       32'(bus.ina),       32'(head[15:8]));
            chk("m_inb",       32'(bus.inb),       32'(head[7:0]));
            chk("m_full",      32'(bus.full),      32'(sz == DEPTH));
            chk("m_empty",     32'(bus.empty),     32'(sz == 0));
            chk("m_in_ready",  32'(bus.in_ready),  32'(sz < DEPTH));
        end
    end

    task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_level",     32'(bus.level),     32'd0);
        chk("rst_empty",     32'(bus.empty),     32'd1);
        chk("rst_full",      32'(bus.full),      32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ina",       32'(bus.ina),       32'd0);
        chk("rst_inb",       32'(bus.inb),       32'd0);
        rst_n = 1'b1;
        cyc(0, 8'h00, 8'h00, 0);
        cyc(0, 8'h00, 8'h00, 1);
        chk("idle_level", 32'(bus.level), 32'd0);
        chk("idle_ina",   32'(bus.ina),   32'd0);

        // Single push, hold while consumer stalls
        cyc(1, 8'h12, 8'h34, 0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_ina",   32'(bus.ina),       32'h12);
            chk("hold_inb",   32'(bus.inb),       32'h34);
            chk("hold_level", 32'(bus.level),     32'd1);
            cyc(0, 8'h00, 8'h00, 0);
        end
        cyc(0, 8'h00, 8'h00, 1);
        chk("drain1_level", 32'(bus.level), 32'd0);
        chk("drain1_ina",   32'(bus.ina),   32'd0);

        // Fill to DEPTH; fifth pair must wait
        for (int i = 0; i < 4; i++) cyc(1, 8'h10 + 8'(i), 8'h20 + 8'(i), 0);
        chk("fill_level",    32'(bus.level),    32'd4);
        chk("fill_full",     32'(bus.full),     32'd1);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        cyc(1, 8'h14, 8'h24, 0);
        chk("blocked_level", 32'(bus.level), 32'd4);
        chk("blocked_ina",   32'(bus.ina),   32'h10);
        // Full with push and pop together: pop only
        cyc(1, 8'h14, 8'h24, 1);
        chk("fullpp_level", 32'(bus.level), 32'd3);
        chk("fullpp_ina",   32'(bus.ina),   32'h11);
        cyc(1, 8'h14, 8'h24, 0);
        chk("held_accept_level", 32'(bus.level), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("order_ina", 32'(bus.ina), 32'h10 + 32'(i));
            chk("order_inb", 32'(bus.inb), 32'h20 + 32'(i));
            cyc(0, 8'h00, 8'h00, 1);
        end
        chk("drain2_empty", 32'(bus.empty), 32'd1);

        // Sustained push+pop, a=b=n, pointers wrap repeatedly
        cyc(1, 8'd0, 8'd0, 0);
        for (int n = 1; n <= 20; n++) begin
            chk("stream_ina", 32'(bus.ina), 32'(n - 1));
            cyc(1, 8'(n), 8'(n), 1);
            chk("stream_level", 32'(bus.level), 32'd1);
        end
        chk("stream_last", 32'(bus.ina), 32'd20);
        cyc(0, 8'h00, 8'h00, 1);
        chk("stream_empty", 32'(bus.empty), 32'd1);

        // Asynchronous reset with three pairs stored
        for (int i = 0; i < 3; i++) cyc(1, 8'hA0 + 8'(i), 8'hB0 + 8'(i), 0);
        bus.in_valid = 1'b0;
        chk("pre_rst_level", 32'(bus.level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level",     32'(bus.level),     32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_ina",       32'(bus.ina),       32'd0);
        chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("arst_empty",     32'(bus.empty),     32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 8'h5A, 8'hA5, 0);
        bus.in_valid = 1'b0;
        chk("post_rst_ina",   32'(bus.ina),   32'h5A);
        chk("post_rst_inb",   32'(bus.inb),   32'hA5);
        chk("post_rst_level", 32'(bus.level), 32'd1);
        cyc(0, 8'h00, 8'h00, 1);
        cyc(0, 8'h00, 8'h00, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
